// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED sequencer: mode encoding, mode order and the
// pattern each mode starts from.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_t;

  localparam int unsigned INIT_BLINK  = 0;
  localparam int unsigned INIT_CHASE  = 1;
  localparam int unsigned INIT_BOUNCE = 1;
  localparam int unsigned INIT_COUNT  = 0;

  // Modes cycle in encoding order, wrapping COUNT back to BLINK.
  function automatic mode_t next_mode(mode_t m);
    return mode_t'(m + 2'd1);
  endfunction

  function automatic int unsigned init_pattern(mode_t m);
    int unsigned p;
    case (m)
      MODE_CHASE:  p = INIT_CHASE;
      MODE_BOUNCE: p = INIT_BOUNCE;
      MODE_COUNT:  p = INIT_COUNT;
      default:     p = INIT_BLINK;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/led_sequencer_key_debounce.sv
// Pushbutton front end: 2-flop synchronizer, level debounce and a one-cycle press pulse
// on an accepted released->pressed transition of the active-low key.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_ni,
  output logic press_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    // Only a level that stays different for the full window is accepted.
    if (sync2_q != stable_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    press_d = stable_q & ~stable_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= key_ni;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/led_sequencer.sv
// Animated LED pattern generator: step prescaler, speed divider and mode FSM.
// Define LEDSEQ_FAST_SIM_EN to shrink the prescaler and debounce windows to 4 cycles.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned TICK_HZ         = 4,
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             KEY_MODE,
  input  logic [1:0]       SW_SPEED,
  input  logic             SW_PAUSE,
  output logic [WIDTH-1:0] LEDG,
  output logic [1:0]       MODE,
  output logic             TICK
);

`ifdef LEDSEQ_FAST_SIM_EN
  localparam int unsigned PrescLimit = 4;
  localparam int unsigned DebCycles  = 4;
`else
  localparam int unsigned PrescLimit = CLK_HZ / TICK_HZ;
  localparam int unsigned DebCycles  = DEBOUNCE_CYCLES;
`endif
  localparam int unsigned PW = $clog2(PrescLimit);

  logic [PW-1:0]    presc_q, presc_d;
  logic [2:0]       spd_cnt_q, spd_cnt_d;
  logic [WIDTH-1:0] led_q, led_d;
  mode_t            mode_q, mode_d;
  logic             dir_left_q, dir_left_d;
  logic             tick_q;
  logic             base_tick, step, press;
  logic [3:0]       spd_lim;

  key_debounce #(
    .DEBOUNCE_CYCLES(DebCycles)
  ) u_key_debounce (
    .clk_i  (CLOCK_50),
    .rst_i  (RESET),
    .key_ni (KEY_MODE),
    .press_o(press)
  );

  always_comb begin
    base_tick  = (presc_q == PW'(PrescLimit - 1));
    spd_lim    = (4'd1 << SW_SPEED) - 4'd1;
    // >= rather than == so lowering SW_SPEED mid-count cannot strand the counter.
    step       = base_tick & ~SW_PAUSE & ({1'b0, spd_cnt_q} >= spd_lim);
    presc_d    = base_tick ? '0 : presc_q + PW'(1);
    spd_cnt_d  = spd_cnt_q;
    mode_d     = mode_q;
    led_d      = led_q;
    dir_left_d = dir_left_q;
    if (base_tick && !SW_PAUSE) begin
      spd_cnt_d = step ? '0 : spd_cnt_q + 3'd1;
    end
    // A press restarts the timing and overrides any step on the same edge.
    if (press) begin
      mode_d     = next_mode(mode_q);
      led_d      = WIDTH'(init_pattern(next_mode(mode_q)));
      dir_left_d = 1'b1;
      presc_d    = '0;
      spd_cnt_d  = '0;
    end else if (step) begin
      unique case (mode_q)
        MODE_BLINK: led_d = ~led_q;
        MODE_CHASE: led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
        MODE_BOUNCE: begin
          if (dir_left_q) begin
            if (led_q[WIDTH-1]) begin
              led_d      = led_q >> 1;
              dir_left_d = 1'b0;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              led_d      = led_q << 1;
              dir_left_d = 1'b1;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
        MODE_COUNT: led_d = led_q + WIDTH'(1);
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      presc_q    <= '0;
      spd_cnt_q  <= '0;
      led_q      <= '0;
      mode_q     <= MODE_BLINK;
      dir_left_q <= 1'b1;
      tick_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      spd_cnt_q  <= spd_cnt_d;
      led_q      <= led_d;
      mode_q     <= mode_d;
      dir_left_q <= dir_left_d;
      tick_q     <= base_tick;
    end
  end

  assign LEDG = led_q;
  assign MODE = mode_q;
  assign TICK = tick_q;

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Drives the board LEDs with a selectable animated pattern, replacing the fixed 1 s toggle on LEDG.
- Contains its own step-rate prescaler (upstream tick source) and a mode state machine that consumes the ticks.
- Mode is advanced by a debounced pushbutton; speed and pause come from switches.
- Sits at top level directly between the board inputs (KEY/SW) and the LEDG pins.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- TICK_HZ, 4, base step rate; PRESC_LIMIT = CLK_HZ/TICK_HZ, which must be >= 2.
- WIDTH, 4, number of LEDs driven; must be >= 2.
- DEBOUNCE_CYCLES, 1000000, stable cycles (20 ms) required to accept a key level.

Ports:
- CLOCK_50  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- KEY_MODE  in  1  raw pushbutton, active-low (pressed = 0), asynchronous.
- SW_SPEED  in  2  step divider select: a step occurs every 2^SW_SPEED base ticks.
- SW_PAUSE  in  1  1 = freeze the pattern.
- LEDG  out  WIDTH  registered LED pattern.
- MODE  out  2  current mode: 0 BLINK, 1 CHASE, 2 BOUNCE, 3 COUNT.
- TICK  out  1  one-cycle base-tick pulse, registered.

Behaviour:
- One clock domain, CLOCK_50. RESET is synchronous, active-high.
- Reset values:
  - LEDG = 0, MODE = BLINK, TICK = 0.
  - Prescaler, speed counter and debounce counter = 0.
  - Key synchronizer flops and debounced level = 1 (released).
  - BOUNCE direction = left (towards MSB).
  - A reset asserted mid-operation takes effect on the next edge with the same values.
- Prescaler:
  - Counts 0..PRESC_LIMIT-1, then wraps to 0; width is $clog2(PRESC_LIMIT).
  - base_tick = (presc == PRESC_LIMIT-1).
  - TICK is registered from base_tick, so it is high in the cycle after the wrap edge.
  - The prescaler always runs, including during pause.
- Speed divider:
  - On each base_tick: if spd_cnt >= (2^SW_SPEED)-1, assert step and clear spd_cnt; otherwise spd_cnt+1.
  - The >= compare guarantees no lockup if SW_SPEED is lowered mid-count.
  - While SW_PAUSE = 1: spd_cnt holds, step is suppressed, LEDG holds.
- Step action by mode (LEDG updates on the same edge as the step):
  - BLINK: LEDG <= ~LEDG, alternating 0000 and 1111.
  - CHASE: rotate left; the MSB wraps to bit 0 (0001, 0010, 0100, 1000, 0001).
  - BOUNCE: one-hot moving in the current direction; the direction flips when the bit reaches the MSB or LSB (…1000, 0100, 0010, 0001, 0010…). Bit 0 never wraps directly to the MSB.
  - COUNT: LEDG <= LEDG+1, wrapping from all-ones to 0.
- Key path:
  - 2-flop synchronizer, then debounce.
  - Debounce counter increments while the synced level differs from the stable level, and clears when they are equal.
  - At DEBOUNCE_CYCLES-1 the stable level takes the synced value and the counter clears.
  - A press event is a registered 1->0 transition of the stable level (one-cycle pulse).
  - Latency from KEY_MODE low to MODE change is 2 + DEBOUNCE_CYCLES + 2 cycles, ±1.
- Mode advance on a press event:
  - Order: BLINK -> CHASE -> BOUNCE -> COUNT -> BLINK.
  - On the same edge, load the initial pattern: BLINK 0, CHASE 1, BOUNCE 1 with direction left, COUNT 0.
  - Clear the prescaler and spd_cnt, so the first step comes a full period later.
  - A press is honoured during pause; the pattern loads and then holds.
- Simultaneous step and press: the press wins and the step is discarded.
- Key release generates no event. A glitch shorter than DEBOUNCE_CYCLES is ignored.

Optional Feature:
- Macro: LEDSEQ_FAST_SIM_EN.
- Defined: PRESC_LIMIT is forced to 4 and DEBOUNCE_CYCLES is forced to 4, for simulation only.
- Undefined: the parameter-derived values are used.
- Ports and all other behaviour are identical in both cases.

Decomposition:
- Package led_seq_pkg holds:
  - mode_t, a 2-bit enum MODE_BLINK, MODE_CHASE, MODE_BOUNCE, MODE_COUNT;
  - a next-mode function;
  - the initial-pattern constants.
- One sub-module, key_debounce: synchronizer plus debounce counter plus the press-event pulse, parameterised by DEBOUNCE_CYCLES.
- The prescaler, speed divider and mode FSM stay in led_sequencer.

Test Plan:
All scenarios run with LEDSEQ_FAST_SIM_EN defined and WIDTH = 4.
1. Reset release, SW_SPEED = 0, KEY high -> LEDG = 0000, MODE = 0; first step 4 cycles after release gives LEDG = 1111; next step (4 cycles later) gives 0000; TICK pulses every 4 cycles.
2. Hold KEY_MODE low 12 cycles -> exactly one MODE change to 1 with LEDG = 0001; next steps give 0010, 0100, 1000, 0001; release causes no change.
3. Second press -> MODE = 2, LEDG = 0001; steps give 0010, 0100, 1000, 0100, 0010, 0001, 0010.
4. Third press, SW_SPEED = 2 -> MODE = 3; a step every 16 cycles; LEDG 0000 -> 0001 …; after 16 steps LEDG = 0000 (wrap). Lowering SW_SPEED to 0 mid-count -> next base tick steps.
5. KEY low 2 cycles (glitch) -> MODE unchanged. SW_PAUSE = 1 -> TICK keeps pulsing, LEDG frozen; SW_PAUSE = 0 resumes from the frozen value.
6. RESET for 1 cycle while in COUNT at LEDG = 0101 -> next cycle LEDG = 0000, MODE = 0, TICK = 0. A press event coinciding with a step -> the mode's initial pattern loads with no step applied.
